// File: rtl/coherence_pkg.sv
// Shared definitions for the trace-driven processor model: instruction kinds,
// FSM states, the request payload layout and a bench-side instruction packer.
package coherence_pkg;

  localparam logic [1:0] KIND_NOP   = 2'b00;
  localparam logic [1:0] KIND_READ  = 2'b01;
  localparam logic [1:0] KIND_WRITE = 2'b10;
  localparam logic [1:0] KIND_HALT  = 2'b11;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_INSTR_W = 2 + DEF_ADDR_W + DEF_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DONE
  } procState_t;

  typedef struct packed {
    logic                  op;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } reqPayload_t;

  // Packs {kind, addr, data} for the default 8-bit address/data configuration.
  function automatic logic [DEF_INSTR_W-1:0] packInstr(input logic [1:0]            kind,
                                                       input logic [DEF_ADDR_W-1:0] addr,
                                                       input logic [DEF_DATA_W-1:0] data);
    return {kind, addr, data};
  endfunction

endpackage

// File: rtl/trace_processor_if.sv
// Request/response channel between a trace processor and its cache controller.
interface trace_processor_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_src;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data, req_src,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_src,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/trace_mem.sv
// Program store: register array, one synchronous write port, one asynchronous read port.
module trace_mem #(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned INSTR_W = 18,
  localparam int unsigned PC_W    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wrEn,
  input  logic [PC_W-1:0]    wrAddr,
  input  logic [INSTR_W-1:0] wrData,
  input  logic [PC_W-1:0]    rdAddr,
  output logic [INSTR_W-1:0] rdInstr_c
);
  logic [INSTR_W-1:0] mem [DEPTH];

  // Deliberately not reset: contents are defined only once loaded.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdInstr_c = mem[rdAddr];
endmodule

// File: rtl/trace_processor.sv
// Trace-driven core model: fetches instructions from a loadable program memory and
// issues blocking READ/WRITE requests to its private cache controller.
module trace_processor
  import coherence_pkg::*;
#(
  parameter  int unsigned ADDR_W  = 8,
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned PROC_ID = 0,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned PC_W    = $clog2(DEPTH),
  localparam int unsigned INSTR_W = 2 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  trace_processor_if.master  bus,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   n_reads,
  output logic [CNT_W-1:0]   n_writes,
  output logic [CNT_W-1:0]   n_stall
);
  procState_t        state;
  logic              reqValid;
  logic              reqOp;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;

  logic [INSTR_W-1:0] instr_c;
  logic [1:0]         kind_c;
  logic [ADDR_W-1:0]  fetchAddr_c;
  logic [DATA_W-1:0]  fetchData_c;
  logic               idleLike_c;
  logic               lastSlot_c;
  logic [PC_W-1:0]    advPc_c;
  procState_t         advState_c;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign idleLike_c  = (state == ST_IDLE) || (state == ST_DONE);
  assign kind_c      = instr_c[INSTR_W-1 -: 2];
  assign fetchAddr_c = instr_c[DATA_W +: ADDR_W];
  assign fetchData_c = instr_c[DATA_W-1:0];

  // The last slot retires into DONE with pc held, so pc never wraps.
  assign lastSlot_c  = (pc == PC_W'(DEPTH - 1));
  assign advPc_c     = lastSlot_c ? pc : pc + PC_W'(1);
  assign advState_c  = lastSlot_c ? ST_DONE : ST_FETCH;

  trace_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) uMem (
    .clk       (clk),
    .wrEn      (prog_we && idleLike_c),
    .wrAddr    (prog_addr),
    .wrData    (prog_data),
    .rdAddr    (pc),
    .rdInstr_c (instr_c)
  );

  assign bus.req_valid = reqValid;
  assign bus.req_op    = reqOp;
  assign bus.req_addr  = reqAddr;
  assign bus.req_data  = reqData;
  assign bus.req_src   = 2'(PROC_ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      reqValid <= 1'b0;
      reqOp    <= 1'b0;
      reqAddr  <= '0;
      reqData  <= '0;
      rd_data  <= '0;
      n_reads  <= '0;
      n_writes <= '0;
      n_stall  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_FETCH;
            pc       <= '0;
            rd_data  <= '0;
            n_reads  <= '0;
            n_writes <= '0;
            n_stall  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_FETCH: begin
          case (kind_c)
            KIND_NOP: begin
              pc    <= advPc_c;
              state <= advState_c;
              busy  <= !lastSlot_c;
              done  <= lastSlot_c;
            end
            KIND_HALT: begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: begin
              reqValid <= 1'b1;
              reqOp    <= (kind_c == KIND_WRITE);
              reqAddr  <= fetchAddr_c;
              reqData  <= (kind_c == KIND_WRITE) ? fetchData_c : '0;
              state    <= ST_ISSUE;
            end
          endcase
        end
        ST_ISSUE: begin
          if (bus.req_ready) begin
            reqValid <= 1'b0;
            if (reqOp) begin
              n_writes <= satInc(n_writes);
              pc       <= advPc_c;
              state    <= advState_c;
              busy     <= !lastSlot_c;
              done     <= lastSlot_c;
            end else begin
              state <= ST_WAIT_RSP;
            end
          end else begin
            n_stall <= satInc(n_stall);
          end
        end
        ST_WAIT_RSP: begin
          if (bus.rsp_valid) begin
            rd_data <= bus.rsp_data;
            n_reads <= satInc(n_reads);
            pc      <= advPc_c;
            state   <= advState_c;
            busy    <= !lastSlot_c;
            done    <= lastSlot_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
